nn_wmem_arbiter: RTL and testbench
==================================

Name: nn_wmem_arbiter

Overview:
- Shares the single-port weight RAM of the feed-forward NN between two requesters:
  - a host loader, which writes weights;
  - the inference engine, which reads layer weights.
- Sits between both requesters and the RAM's a/d/we/q port.
- Grants one access at a time. Round-robin arbitration on ties, with an engine lock for inference bursts.
- Returns engine read data with a valid strobe and flags host starvation.

Parameters:
AWIDTH, 4, RAM address width
DWIDTH, 1024, RAM word width (one full layer weight vector)
CWIDTH, 8, width of host wait counter
STARVE_LIMIT, 64, host wait count at or above which host_starved asserts

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  asynchronous, active-low reset
host_req  input  1  host write request, held with addr/data until host_gnt
host_addr  input  AWIDTH  host write address
host_data  input  DWIDTH  host write data
host_gnt  output  1  one-cycle pulse: write issued to RAM this cycle
eng_req  input  1  engine read request, held with addr until eng_gnt
eng_addr  input  AWIDTH  engine read address
eng_lock  input  1  engine priority lock (held for a whole inference run)
eng_gnt  output  1  one-cycle pulse: read issued to RAM this cycle
eng_rvalid  output  1  one-cycle pulse: eng_rdata valid
eng_rdata  output  DWIDTH  read data, combinational pass-through of ram_q
ram_a  output  AWIDTH  RAM address
ram_d  output  DWIDTH  RAM write data
ram_we  output  1  RAM write enable
ram_q  input  DWIDTH  RAM registered read data (1-cycle latency)
host_starved  output  1  host_wait_cnt >= STARVE_LIMIT

Behaviour:
- Reset (RST=0, any time, asynchronous):
  - state=IDLE.
  - host_gnt, eng_gnt, eng_rvalid, ram_we = 0; ram_a=0; ram_d=0.
  - last_owner=HOST; host_wait_cnt=0; host_starved=0.
  - An in-flight read is dropped: no eng_rvalid after reset release.
- FSM states: IDLE, GNT_HOST, GNT_ENG. All outputs are registered except eng_rdata.
- Cycle numbering: cycle n is the interval after rising edge n.
- IDLE:
  - Samples the requests at each edge.
  - Only host_req → GNT_HOST.
  - Only eng_req → GNT_ENG.
  - Both with eng_lock=1 → GNT_ENG; last_owner is not updated.
  - Both with eng_lock=0 → the requester that is not last_owner wins; last_owner is updated.
  - Neither → stay in IDLE.
  - eng_lock=1 with only host_req → host is granted (the lock wins ties only, it never blocks an idle RAM).
- GNT_HOST (exactly 1 cycle): host_gnt=1, ram_we=1, ram_a=host_addr, ram_d=host_data → IDLE.
- GNT_ENG (exactly 1 cycle): eng_gnt=1, ram_we=0, ram_a=eng_addr → IDLE.
  - eng_rvalid=1 in the following cycle, with eng_rdata=ram_q.
- Requests are ignored while in GNT_*. This lets a requester drop req after seeing its gnt without a double grant.
- Timing: request in cycle 0 → gnt in cycle 1 → read data valid in cycle 2. Maximum throughput is 1 access per 2 cycles.
- Outside GNT_HOST: ram_we=0. ram_a and ram_d hold their last value.
- host_wait_cnt:
  - +1 every cycle with host_req=1 and host_gnt=0, saturating at 2^CWIDTH-1.
  - Cleared in the host_gnt cycle.
  - host_starved is registered from the compare.
- No address range checks; the RAM wraps or ignores addresses per its own depth.

Test Plan:
1. Reset → all outputs 0.
   - Release reset, no requests for 10 cycles → ram_we never 1, no gnt.
2. Host write: host_req=1, addr=2, data=0xA5…A5 → host_gnt, ram_we=1, ram_a=2 in cycle 1.
   - Then engine reads addr=2 → eng_rvalid in cycle 2 after its request, eng_rdata=0xA5…A5.
3. Tie with eng_lock=0, both holding req continuously (re-raise after each gnt) → grants alternate ENG, HOST, ENG, HOST; the first grant goes to the engine.
4. eng_lock=1, both requesting, engine re-requests every IDLE for 200 cycles → only eng_gnt.
   - host_starved rises when the wait count reaches 64.
   - Drop the lock → host granted next arbitration; counter=0 and host_starved=0 the cycle after.
5. Only host_req with eng_lock=1 → host granted in cycle 1.
6. Reset asserted during GNT_ENG → no eng_rvalid afterwards, outputs 0 immediately.
   - After release, a pending eng_req is granted again with correct data.

Source files
------------

// File: rtl/nn_wmem_arbiter.sv
// Arbiter sharing the single-port NN weight RAM between the host loader (writes)
// and the inference engine (reads). One access per two cycles; engine lock wins ties.
module nn_wmem_arbiter #(
    parameter int AWIDTH       = 4,
    parameter int DWIDTH       = 1024,
    parameter int CWIDTH       = 8,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              host_req,
    input  logic [AWIDTH-1:0] host_addr,
    input  logic [DWIDTH-1:0] host_data,
    output logic              host_gnt,
    input  logic              eng_req,
    input  logic [AWIDTH-1:0] eng_addr,
    input  logic              eng_lock,
    output logic              eng_gnt,
    output logic              eng_rvalid,
    output logic [DWIDTH-1:0] eng_rdata,
    output logic [AWIDTH-1:0] ram_a,
    output logic [DWIDTH-1:0] ram_d,
    output logic              ram_we,
    input  logic [DWIDTH-1:0] ram_q,
    output logic              host_starved
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_HOST = 2'd1,
        GNT_ENG  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_HOST = 1'b0,
        OWN_ENG  = 1'b1
    } owner_t;

    localparam logic [CWIDTH-1:0] CNT_MAX = {CWIDTH{1'b1}};

    state_t              state_q;
    owner_t              last_owner_q;
    logic                host_gnt_q;
    logic                eng_gnt_q;
    logic                eng_rvalid_q;
    logic                ram_we_q;
    logic [AWIDTH-1:0]   ram_a_q;
    logic [DWIDTH-1:0]   ram_d_q;
    logic [CWIDTH-1:0]   host_wait_cnt_q;
    logic [CWIDTH-1:0]   host_wait_cnt_d;
    logic                host_starved_q;
    logic                host_starved_d;

    logic                pick_host;
    logic                pick_eng;
    logic                upd_owner;

    // Arbitration is only evaluated in IDLE; requests seen during a grant cycle are ignored.
    always_comb begin
        pick_host = 1'b0;
        pick_eng  = 1'b0;
        upd_owner = 1'b0;
        if (state_q == IDLE) begin
            if (host_req && eng_req) begin
                if (eng_lock) begin
                    pick_eng = 1'b1;
                end else begin
                    upd_owner = 1'b1;
                    if (last_owner_q == OWN_ENG) begin
                        pick_host = 1'b1;
                    end else begin
                        pick_eng = 1'b1;
                    end
                end
            end else if (host_req) begin
                pick_host = 1'b1;
            end else if (eng_req) begin
                pick_eng = 1'b1;
            end
        end
    end

    // Wait counter reads zero during the host grant cycle itself.
    always_comb begin
        host_wait_cnt_d = host_wait_cnt_q;
        if (pick_host) begin
            host_wait_cnt_d = '0;
        end else if (host_req && !host_gnt_q && (host_wait_cnt_q != CNT_MAX)) begin
            host_wait_cnt_d = host_wait_cnt_q + 1'b1;
        end
        host_starved_d = (int'(host_wait_cnt_d) >= STARVE_LIMIT);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q         <= IDLE;
            last_owner_q    <= OWN_HOST;
            host_gnt_q      <= 1'b0;
            eng_gnt_q       <= 1'b0;
            eng_rvalid_q    <= 1'b0;
            ram_we_q        <= 1'b0;
            ram_a_q         <= '0;
            ram_d_q         <= '0;
            host_wait_cnt_q <= '0;
            host_starved_q  <= 1'b0;
        end else begin
            host_gnt_q      <= 1'b0;
            eng_gnt_q       <= 1'b0;
            ram_we_q        <= 1'b0;
            eng_rvalid_q    <= (state_q == GNT_ENG);
            host_wait_cnt_q <= host_wait_cnt_d;
            host_starved_q  <= host_starved_d;
            case (state_q)
                IDLE: begin
                    if (pick_host) begin
                        state_q    <= GNT_HOST;
                        host_gnt_q <= 1'b1;
                        ram_we_q   <= 1'b1;
                        ram_a_q    <= host_addr;
                        ram_d_q    <= host_data;
                        if (upd_owner) begin
                            last_owner_q <= OWN_HOST;
                        end
                    end else if (pick_eng) begin
                        state_q   <= GNT_ENG;
                        eng_gnt_q <= 1'b1;
                        ram_a_q   <= eng_addr;
                        if (upd_owner) begin
                            last_owner_q <= OWN_ENG;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign host_gnt     = host_gnt_q;
    assign eng_gnt      = eng_gnt_q;
    assign eng_rvalid   = eng_rvalid_q;
    assign eng_rdata    = ram_q;
    assign ram_a        = ram_a_q;
    assign ram_d        = ram_d_q;
    assign ram_we       = ram_we_q;
    assign host_starved = host_starved_q;

endmodule

// File: tb/tb_nn_wmem_arbiter.sv
// Scoreboard bench for nn_wmem_arbiter: stimulus queues expected grants/read data,
// a negedge monitor pops and compares whenever the DUT pulses a grant or rvalid.
module tb_nn_wmem_arbiter;

    localparam int AW = 4;
    localparam int DW = 1024;
    localparam int CW = 8;
    localparam int SL = 64;

    localparam logic [DW-1:0] PAT_A5 = {128{8'hA5}};
    localparam logic [DW-1:0] PAT_3C = {128{8'h3C}};
    localparam logic [DW-1:0] PAT_5A = {128{8'h5A}};
    localparam logic [DW-1:0] PAT_C3 = {128{8'hC3}};

    logic          CLK;
    logic          RST;
    logic          host_req;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_data;
    logic          host_gnt;
    logic          eng_req;
    logic [AW-1:0] eng_addr;
    logic          eng_lock;
    logic          eng_gnt;
    logic          eng_rvalid;
    logic [DW-1:0] eng_rdata;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_d;
    logic          ram_we;
    logic [DW-1:0] ram_q;
    logic          host_starved;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic          is_host;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } gnt_exp_t;

    gnt_exp_t      gnt_q[$];
    logic [DW-1:0] rd_q[$];
    gnt_exp_t      mon_e;
    logic [DW-1:0] mon_d;

    logic [DW-1:0] mem [16];

    nn_wmem_arbiter #(
        .AWIDTH(AW), .DWIDTH(DW), .CWIDTH(CW), .STARVE_LIMIT(SL)
    ) dut (
        .CLK(CLK), .RST(RST),
        .host_req(host_req), .host_addr(host_addr), .host_data(host_data), .host_gnt(host_gnt),
        .eng_req(eng_req), .eng_addr(eng_addr), .eng_lock(eng_lock), .eng_gnt(eng_gnt),
        .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
        .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q),
        .host_starved(host_starved)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural single-port RAM, read-first, one-cycle read latency.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        ram_q = '0;
    end
    always @(posedge CLK) begin
        if (ram_we) mem[ram_a] <= ram_d;
        ram_q <= mem[ram_a];
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got low128 0x%h expected low128 0x%h (t=%0t)",
                     name, act[127:0], exp[127:0], $time);
        end
    endtask

    task automatic exp_grant(input logic is_host, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        gnt_exp_t e;
        e.is_host = is_host;
        e.addr    = addr;
        e.data    = data;
        gnt_q.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_host_gnt"}, host_gnt, 1'b0);
        chk1({tag, "_eng_gnt"}, eng_gnt, 1'b0);
        chk1({tag, "_eng_rvalid"}, eng_rvalid, 1'b0);
        chk1({tag, "_ram_we"}, ram_we, 1'b0);
        chka({tag, "_ram_a"}, ram_a, '0);
        chkd({tag, "_ram_d"}, ram_d, '0);
        chk1({tag, "_host_starved"}, host_starved, 1'b0);
    endtask

    // Monitor: one transaction line per grant / read return.
    always @(negedge CLK) begin
        if (RST) begin
            if (host_gnt || eng_gnt) begin
                if (gnt_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_grant: got host_gnt=%b eng_gnt=%b expected none (t=%0t)",
                             host_gnt, eng_gnt, $time);
                end else begin
                    mon_e = gnt_q.pop_front();
                    $display("grant %s addr=0x%0h we=%b (t=%0t)", host_gnt ? "HOST" : "ENG", ram_a, ram_we, $time);
                    chk1("grant_host_gnt", host_gnt, mon_e.is_host);
                    chk1("grant_eng_gnt", eng_gnt, ~mon_e.is_host);
                    chk1("grant_ram_we", ram_we, mon_e.is_host);
                    chka("grant_ram_a", ram_a, mon_e.addr);
                    if (mon_e.is_host) chkd("grant_ram_d", ram_d, mon_e.data);
                end
            end
            if (eng_rvalid) begin
                if (rd_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rvalid: got eng_rvalid=1 expected 0 (t=%0t)", $time);
                end else begin
                    mon_d = rd_q.pop_front();
                    $display("rdata low32=0x%h (t=%0t)", eng_rdata[31:0], $time);
                    chkd("rvalid_rdata", eng_rdata, mon_d);
                end
            end
        end
    end

    initial begin
        RST = 1'b0;
        host_req = 1'b0; host_addr = '0; host_data = '0;
        eng_req = 1'b0; eng_addr = '0; eng_lock = 1'b0;

        // 1: reset values, then idle with no requests
        #2;
        chk_all_zero("reset");
        @(negedge CLK);
        RST = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            chk1("idle_ram_we", ram_we, 1'b0);
            chk1("idle_gnt", host_gnt | eng_gnt, 1'b0);
        end

        // 2: host write then engine read-back
        host_req = 1'b1; host_addr = 4'd2; host_data = PAT_A5;
        exp_grant(1'b1, 4'd2, PAT_A5);
        @(negedge CLK);
        chk1("t2_host_gnt_c1", host_gnt, 1'b1);
        host_req = 1'b0;
        @(negedge CLK);
        eng_req = 1'b1; eng_addr = 4'd2;
        exp_grant(1'b0, 4'd2, '0);
        rd_q.push_back(PAT_A5);
        @(negedge CLK);
        chk1("t2_eng_gnt_c1", eng_gnt, 1'b1);
        eng_req = 1'b0;
        @(negedge CLK);
        chk1("t2_rvalid_c2", eng_rvalid, 1'b1);

        // 3: round-robin on ties, starting from reset ownership
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        exp_grant(1'b0, 4'd2, '0);          rd_q.push_back(PAT_A5);
        exp_grant(1'b1, 4'd5, PAT_3C);
        exp_grant(1'b0, 4'd2, '0);          rd_q.push_back(PAT_A5);
        exp_grant(1'b1, 4'd5, PAT_3C);
        host_req = 1'b1; host_addr = 4'd5; host_data = PAT_3C;
        eng_req = 1'b1; eng_addr = 4'd2; eng_lock = 1'b0;
        repeat (7) @(negedge CLK);
        chk1("t3_fourth_is_host", host_gnt, 1'b1);
        host_req = 1'b0; eng_req = 1'b0;
        repeat (2) @(negedge CLK);

        // 4: engine lock starves the host
        for (int g = 0; g < 100; g++) begin
            exp_grant(1'b0, 4'd2, '0);
            rd_q.push_back(PAT_A5);
        end
        host_req = 1'b1; host_addr = 4'd9; host_data = PAT_5A;
        eng_req = 1'b1; eng_addr = 4'd2; eng_lock = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge CLK);
            chk1("t4_starved", host_starved, (k >= SL));
        end
        eng_lock = 1'b0; eng_req = 1'b0;
        exp_grant(1'b1, 4'd9, PAT_5A);
        @(negedge CLK);
        chk1("t4_host_gnt_after_unlock", host_gnt, 1'b1);
        host_req = 1'b0;
        @(negedge CLK);
        chk1("t4_starved_cleared", host_starved, 1'b0);

        // 5: lock never blocks a lone host request
        eng_lock = 1'b1;
        host_req = 1'b1; host_addr = 4'd7; host_data = PAT_C3;
        exp_grant(1'b1, 4'd7, PAT_C3);
        @(negedge CLK);
        chk1("t5_host_gnt_c1", host_gnt, 1'b1);
        host_req = 1'b0; eng_lock = 1'b0;
        @(negedge CLK);

        // 6: reset during GNT_ENG drops the in-flight read
        eng_req = 1'b1; eng_addr = 4'd7;
        exp_grant(1'b0, 4'd7, '0);
        @(negedge CLK);
        chk1("t6_eng_gnt_c1", eng_gnt, 1'b1);
        #2 RST = 1'b0;
        #1 chk_all_zero("t6_async");
        @(negedge CLK);
        chk1("t6_no_rvalid", eng_rvalid, 1'b0);
        RST = 1'b1;
        exp_grant(1'b0, 4'd7, '0);
        rd_q.push_back(PAT_C3);
        @(negedge CLK);
        chk1("t6_regrant", eng_gnt, 1'b1);
        eng_req = 1'b0;
        @(negedge CLK);
        chk1("t6_rvalid", eng_rvalid, 1'b1);
        repeat (3) @(negedge CLK);

        chk1("sb_grants_drained", gnt_q.size() == 0, 1'b1);
        chk1("sb_reads_drained", rd_q.size() == 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
